// File: rtl/pdu_run_ctrl.sv
// Debug-side run controller: debounces the board buttons, holds the user breakpoint
// and sequences run / single-step requests into the pipeline control unit.
module pdu_run_ctrl #(
   parameter int          DB_CYCLES = 4,
   parameter int          CNT_W     = 24,
   parameter logic [31:0] BP_NONE   = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        btn_run,
   input  logic        btn_step,
   input  logic        btn_bp_load,
   input  logic        sw_bp_en,
   input  logic [31:0] bp_addr_in,
   input  logic [31:0] id_pc,
   input  logic        cpu_clk,
   input  logic        cpu_stop,
   output logic        pdu_run,
   output logic [31:0] pdu_breakpoint,
   output logic [2:0]  pdu_state,
   output logic [15:0] step_count
);

   typedef enum logic [2:0] {
      HALT       = 3'd0,
      RUN_PULSE  = 3'd1,
      RUN_MASK   = 3'd2,
      RUN        = 3'd3,
      STEP_PULSE = 3'd4,
      STEP_MASK  = 3'd5,
      STEP_ARM   = 3'd6
   } state_t;

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
   localparam logic [15:0]      WD_LAST = 16'hFFFE;

   state_t           state;
   state_t           state_n;
   logic [3:0]       raw_in;
   logic [3:0]       sync1;
   logic [3:0]       sync2;
   logic [3:0]       stable;
   logic [2:0]       stable_q;
   logic [CNT_W-1:0] db_cnt [4];
   logic             run_evt;
   logic             step_evt;
   logic             load_evt;
   logic             bp_en;
   logic [31:0]      bp_reg;
   logic             cpu_clk_q;
   logic             clk_edge;
   logic [15:0]      wd_cnt;
   logic             step_inc;
   logic             in_mask;

   // bit 0 run, bit 1 step, bit 2 breakpoint load, bit 3 breakpoint enable switch
   assign raw_in = {sw_bp_en, btn_bp_load, btn_step, btn_run};

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= raw_in;
         sync2 <= sync1;
      end
   end

   // A new level is accepted only after DB_CYCLES consecutive differing samples
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stable   <= '0;
         stable_q <= '0;
         for (int i = 0; i < 4; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         stable_q <= stable[2:0];
         for (int i = 0; i < 4; i++) begin
            if (sync2[i] == stable[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               stable[i] <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   assign run_evt  = stable[0] & ~stable_q[0];
   assign step_evt = stable[1] & ~stable_q[1];
   assign load_evt = stable[2] & ~stable_q[2];
   assign bp_en    = stable[3];
   assign clk_edge = cpu_clk & ~cpu_clk_q;
   assign in_mask  = (state == RUN_MASK) || (state == STEP_MASK);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bp_reg    <= BP_NONE;
         cpu_clk_q <= 1'b0;
      end else begin
         cpu_clk_q <= cpu_clk;
         if (load_evt) begin
            bp_reg <= bp_addr_in;
         end
      end
   end

   // Watchdog only runs while waiting for the first CPU clock edge after a request
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wd_cnt <= '0;
      end else if (in_mask) begin
         wd_cnt <= wd_cnt + 16'd1;
      end else begin
         wd_cnt <= '0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= HALT;
         step_count <= '0;
      end else begin
         state <= state_n;
         if (step_inc) begin
            step_count <= step_count + 16'd1;
         end
      end
   end

   // Breakpoint is masked until the CPU has left the PC it was parked on
   always_comb begin
      state_n        = state;
      step_inc       = 1'b0;
      pdu_run        = 1'b0;
      pdu_breakpoint = BP_NONE;
      case (state)
         HALT: begin
            pdu_breakpoint = bp_en ? bp_reg : BP_NONE;
            if (run_evt) begin
               state_n = RUN_PULSE;
            end else if (step_evt) begin
               state_n = STEP_PULSE;
            end
         end
         RUN_PULSE: begin
            pdu_run = 1'b1;
            state_n = RUN_MASK;
         end
         RUN_MASK: begin
            if (clk_edge) begin
               state_n = RUN;
            end else if (wd_cnt == WD_LAST) begin
               state_n = HALT;
            end
         end
         RUN: begin
            pdu_breakpoint = bp_en ? bp_reg : BP_NONE;
            if (cpu_stop) begin
               state_n = HALT;
            end
         end
         STEP_PULSE: begin
            pdu_run = 1'b1;
            state_n = STEP_MASK;
         end
         STEP_MASK: begin
            if (clk_edge) begin
               state_n = STEP_ARM;
            end else if (wd_cnt == WD_LAST) begin
               state_n = HALT;
            end
         end
         STEP_ARM: begin
            pdu_breakpoint = id_pc;
            if (cpu_stop) begin
               state_n  = HALT;
               step_inc = 1'b1;
            end
         end
         default: begin
            state_n = HALT;
         end
      endcase
   end

   assign pdu_state = state;

endmodule

// File: tb/tb_pdu_run_ctrl.sv
// Directed bench for pdu_run_ctrl: the bench plays the CPU (cpu_clk, cpu_stop, id_pc)
// and the user (buttons, switches), checking state, run pulses and breakpoint value.
module tb_pdu_run_ctrl;

   localparam int          DB_CYCLES = 4;
   localparam logic [31:0] BP_NONE   = 32'hFFFF_FFFF;

   logic        clk;
   logic        rstn;
   logic        btn_run;
   logic        btn_step;
   logic        btn_bp_load;
   logic        sw_bp_en;
   logic [31:0] bp_addr_in;
   logic [31:0] id_pc;
   logic        cpu_clk;
   logic        cpu_stop;
   logic        pdu_run;
   logic [31:0] pdu_breakpoint;
   logic [2:0]  pdu_state;
   logic [15:0] step_count;

   int tests;
   int failures;
   int run_pulses;
   int mask_cycles;

   pdu_run_ctrl #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (24),
      .BP_NONE   (BP_NONE)
   ) dut (
      .clk            (clk),
      .rstn           (rstn),
      .btn_run        (btn_run),
      .btn_step       (btn_step),
      .btn_bp_load    (btn_bp_load),
      .sw_bp_en       (sw_bp_en),
      .bp_addr_in     (bp_addr_in),
      .id_pc          (id_pc),
      .cpu_clk        (cpu_clk),
      .cpu_stop       (cpu_stop),
      .pdu_run        (pdu_run),
      .pdu_breakpoint (pdu_breakpoint),
      .pdu_state      (pdu_state),
      .step_count     (step_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (pdu_run === 1'b1) run_pulses++;
   end

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic apply_stimulus(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_run(input string tag);
      int n;
      n = 0;
      while (pdu_run !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check_output({tag, " pulse seen"}, {31'd0, pdu_run}, 32'd1);
   endtask

   task automatic cpu_tick();
      cpu_clk = 1'b1;
      @(negedge clk);
      cpu_clk = 1'b0;
   endtask

   initial begin
      tests = 0; failures = 0; run_pulses = 0; mask_cycles = 0;
      rstn = 1'b0; btn_run = 1'b0; btn_step = 1'b0; btn_bp_load = 1'b0;
      sw_bp_en = 1'b0; bp_addr_in = '0; id_pc = '0; cpu_clk = 1'b0; cpu_stop = 1'b1;
      apply_stimulus(3);
      check_output("reset state", {29'd0, pdu_state}, 32'd0);
      check_output("reset run", {31'd0, pdu_run}, 32'd0);
      check_output("reset bp", pdu_breakpoint, BP_NONE);
      check_output("reset steps", {16'd0, step_count}, 32'd0);
      rstn = 1'b1;
      apply_stimulus(2);

      // Glitch one sample short of the debounce window
      btn_run = 1'b1;
      apply_stimulus(DB_CYCLES - 1);
      btn_run = 1'b0;
      apply_stimulus(20);
      check_output("glitch pulses", run_pulses, 32'd0);
      check_output("glitch state", {29'd0, pdu_state}, 32'd0);

      // Load breakpoint; address changes after release must not be captured
      sw_bp_en = 1'b1; bp_addr_in = 32'h0000_0010; btn_bp_load = 1'b1;
      apply_stimulus(10);
      btn_bp_load = 1'b0; bp_addr_in = 32'hDEAD_BEEF;
      apply_stimulus(12);
      check_output("halt bp", pdu_breakpoint, 32'h0000_0010);

      // Run to breakpoint
      btn_run = 1'b1;
      wait_run("run1");
      check_output("run1 pulse state", {29'd0, pdu_state}, 32'd1);
      check_output("run1 pulse bp", pdu_breakpoint, BP_NONE);
      cpu_stop = 1'b0;
      apply_stimulus(1);
      check_output("run1 width", {31'd0, pdu_run}, 32'd0);
      check_output("run1 mask state", {29'd0, pdu_state}, 32'd2);
      check_output("run1 mask bp", pdu_breakpoint, BP_NONE);
      apply_stimulus(10);
      check_output("run1 still masked", {29'd0, pdu_state}, 32'd2);
      btn_run = 1'b0;
      cpu_tick();
      check_output("run1 run state", {29'd0, pdu_state}, 32'd3);
      check_output("run1 run bp", pdu_breakpoint, 32'h0000_0010);
      id_pc = 32'h0000_0010; cpu_stop = 1'b1;
      apply_stimulus(1);
      check_output("run1 bp hit halt", {29'd0, pdu_state}, 32'd0);
      check_output("run1 one pulse", run_pulses, 32'd1);
      apply_stimulus(12);

      // Resume from the breakpoint address
      btn_run = 1'b1;
      wait_run("resume");
      cpu_stop = 1'b0;
      check_output("resume pulse bp", pdu_breakpoint, BP_NONE);
      apply_stimulus(1);
      check_output("resume mask state", {29'd0, pdu_state}, 32'd2);
      check_output("resume mask bp", pdu_breakpoint, BP_NONE);
      btn_run = 1'b0;
      cpu_tick();
      id_pc = 32'h0000_0014;
      check_output("resume run bp", pdu_breakpoint, 32'h0000_0010);
      apply_stimulus(3);
      check_output("resume still running", {29'd0, pdu_state}, 32'd3);

      // Step press while running is ignored
      btn_step = 1'b1;
      apply_stimulus(12);
      btn_step = 1'b0;
      apply_stimulus(12);
      check_output("step in run state", {29'd0, pdu_state}, 32'd3);
      check_output("step in run count", {16'd0, step_count}, 32'd0);
      check_output("step in run pulses", run_pulses, 32'd2);
      cpu_stop = 1'b1;
      apply_stimulus(1);
      check_output("resume halt", {29'd0, pdu_state}, 32'd0);

      // Single step
      id_pc = 32'h0000_0020; btn_step = 1'b1;
      wait_run("step1");
      check_output("step1 pulse state", {29'd0, pdu_state}, 32'd4);
      check_output("step1 pulse bp", pdu_breakpoint, BP_NONE);
      cpu_stop = 1'b0;
      apply_stimulus(1);
      check_output("step1 mask state", {29'd0, pdu_state}, 32'd5);
      check_output("step1 mask bp", pdu_breakpoint, BP_NONE);
      btn_step = 1'b0;
      cpu_clk = 1'b1; id_pc = 32'h0000_0024;
      apply_stimulus(1);
      cpu_clk = 1'b0;
      check_output("step1 arm state", {29'd0, pdu_state}, 32'd6);
      check_output("step1 arm bp", pdu_breakpoint, 32'h0000_0024);
      id_pc = 32'h0000_0028;
      apply_stimulus(1);
      check_output("step1 arm tracks pc", pdu_breakpoint, 32'h0000_0028);
      cpu_stop = 1'b1;
      apply_stimulus(1);
      check_output("step1 halt", {29'd0, pdu_state}, 32'd0);
      check_output("step1 count", {16'd0, step_count}, 32'd1);
      check_output("step1 halt bp", pdu_breakpoint, 32'h0000_0010);
      apply_stimulus(12);

      // Simultaneous run and step: run wins
      btn_run = 1'b1; btn_step = 1'b1;
      wait_run("both");
      check_output("both pulse state", {29'd0, pdu_state}, 32'd1);
      cpu_stop = 1'b0;
      apply_stimulus(1);
      btn_run = 1'b0; btn_step = 1'b0;
      cpu_tick();
      check_output("both run state", {29'd0, pdu_state}, 32'd3);
      cpu_stop = 1'b1;
      apply_stimulus(1);
      check_output("both halt", {29'd0, pdu_state}, 32'd0);
      check_output("both count", {16'd0, step_count}, 32'd1);
      apply_stimulus(12);

      // Asynchronous reset while armed for a step
      btn_step = 1'b1;
      wait_run("step2");
      cpu_stop = 1'b0;
      apply_stimulus(1);
      btn_step = 1'b0;
      cpu_tick();
      check_output("step2 arm state", {29'd0, pdu_state}, 32'd6);
      #2 rstn = 1'b0;
      #1;
      check_output("async rst state", {29'd0, pdu_state}, 32'd0);
      check_output("async rst run", {31'd0, pdu_run}, 32'd0);
      check_output("async rst bp", pdu_breakpoint, BP_NONE);
      check_output("async rst count", {16'd0, step_count}, 32'd0);
      apply_stimulus(2);
      rstn = 1'b1;
      apply_stimulus(12);

      // Watchdog: CPU clock never advances after the run pulse
      btn_run = 1'b1;
      wait_run("wd");
      apply_stimulus(1);
      btn_run = 1'b0;
      while (pdu_state === 3'd2 && mask_cycles < 70000) begin
         mask_cycles++;
         apply_stimulus(1);
      end
      check_output("wd mask cycles", mask_cycles, 32'd65535);
      check_output("wd halt", {29'd0, pdu_state}, 32'd0);
      check_output("wd count", {16'd0, step_count}, 32'd0);
      check_output("wd run", {31'd0, pdu_run}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
